// File: rtl/xsim_seq_pkg.sv
// Shared types and constants for the xsim reset/run sequencer.
package xsim_seq_pkg;

    typedef enum logic [2:0] {
        SEQ_HOLD    = 3'd0,
        SEQ_RELEASE = 3'd1,
        SEQ_RUN     = 3'd2,
        SEQ_DRAIN   = 3'd3,
        SEQ_DONE    = 3'd4
    } seq_state_e;

    localparam int DEF_CNT_W = 32;
    localparam int DRAIN_W   = 8;

endpackage

// File: rtl/xsim_reset_seq_if.sv
// Host-facing request/status bundle of the reset/run sequencer.
interface xsim_reset_seq_if
    import xsim_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 2,
    parameter int CNT_W       = DEF_CNT_W
);
    logic                   soft_reset_req;
    logic                   finish_req;
    logic [NUM_DOMAINS-1:0] dom_rst_n;
    logic                   running;
    logic [CNT_W-1:0]       cycle_count;
    logic                   finish;
    logic                   timeout;

    modport master (
        output soft_reset_req, finish_req,
        input  dom_rst_n, running, cycle_count, finish, timeout
    );

    modport slave (
        input  soft_reset_req, finish_req,
        output dom_rst_n, running, cycle_count, finish, timeout
    );
endinterface

// File: rtl/xsim_release_stage.sv
// One reset domain: releases dom_rst_n when the cycle count hits its release point.
module xsim_release_stage #(
    parameter int               CNT_W  = 32,
    parameter logic [CNT_W-1:0] REL_PT = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             soft_clr,
    input  logic             arm,
    input  logic [CNT_W-1:0] cycle_count,
    output logic             dom_rst_n
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dom_rst_n <= 1'b0;
        end else if (soft_clr) begin
            dom_rst_n <= 1'b0;
        end else if (arm && (cycle_count == REL_PT)) begin
            dom_rst_n <= 1'b1;
        end
    end

endmodule

// File: rtl/xsim_reset_seq.sv
// Reset/run sequencer: ordered domain release, cycle count, drained sticky finish.
// Optional RUN-state watchdog enabled by defining XSIM_WATCHDOG_EN.
//   state   | meaning
//   HOLD    | counting toward the first release point
//   RELEASE | some domains released, waiting for the last
//   RUN     | all domains out of reset
//   DRAIN   | finish requested, letting the design settle
//   DONE    | finish asserted, terminal until RST
module xsim_reset_seq
    import xsim_seq_pkg::*;
#(
    parameter int NUM_DOMAINS     = 2,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int BASE_DELAY      = 20,
    parameter int STEP_DELAY      = 0,
    parameter int DRAIN_CYCLES    = 4,
    parameter int WATCHDOG_CYCLES = 1000000
) (
    input logic              CLK,
    input logic              RST,
    xsim_reset_seq_if.slave  bus
);

    localparam logic [2:0] S_HOLD    = SEQ_HOLD;
    localparam logic [2:0] S_RELEASE = SEQ_RELEASE;
    localparam logic [2:0] S_RUN     = SEQ_RUN;
    localparam logic [2:0] S_DRAIN   = SEQ_DRAIN;
    localparam logic [2:0] S_DONE    = SEQ_DONE;

    localparam logic [CNT_W-1:0]   FIRST_PT   = CNT_W'(BASE_DELAY);
    localparam logic [CNT_W-1:0]   LAST_PT    = CNT_W'(BASE_DELAY + (NUM_DOMAINS - 1) * STEP_DELAY);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam longint unsigned    LAST_PT_FULL = longint'(BASE_DELAY) +
                                                  longint'(NUM_DOMAINS - 1) * longint'(STEP_DELAY);

    if (NUM_DOMAINS < 1 || NUM_DOMAINS > 16) begin : g_bad_domains
        $error("xsim_reset_seq: NUM_DOMAINS must be 1..16");
    end
    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 255) begin : g_bad_drain
        $error("xsim_reset_seq: DRAIN_CYCLES must be 1..255");
    end
    if (WATCHDOG_CYCLES < 1) begin : g_bad_watchdog
        $error("xsim_reset_seq: WATCHDOG_CYCLES must be at least 1");
    end
    // Release compares are full-width, so a point beyond the counter range would never match.
    if (CNT_W < 64 && LAST_PT_FULL >= (64'd1 << CNT_W)) begin : g_bad_release_pt
        $error("xsim_reset_seq: release points do not fit in CNT_W");
    end

    logic [2:0]             state;
    logic [CNT_W-1:0]       cycle_cnt;
    logic                   pending;
    logic [DRAIN_W-1:0]     drain_cnt;
    logic                   running_q;
    logic                   finish_q;
    logic [NUM_DOMAINS-1:0] dom_q;
    logic                   soft_clr;
    logic                   arm;
    logic                   wd_hit;

    assign soft_clr = bus.soft_reset_req && (state != S_DONE);
    assign arm      = (state == S_HOLD) || (state == S_RELEASE);

    for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_stage
        xsim_release_stage #(
            .CNT_W  (CNT_W),
            .REL_PT (CNT_W'(BASE_DELAY + i * STEP_DELAY))
        ) u_stage (
            .CLK         (CLK),
            .RST         (RST),
            .soft_clr    (soft_clr),
            .arm         (arm),
            .cycle_count (cycle_cnt),
            .dom_rst_n   (dom_q[i])
        );
    end

`ifdef XSIM_WATCHDOG_EN
    localparam int WD_W = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;

    assign wd_hit = (wd_cnt == WD_W'(WATCHDOG_CYCLES - 1));

    // Held at zero outside RUN, which also clears it on RUN entry.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wd_cnt <= '0;
        end else if (state != S_RUN || soft_clr) begin
            wd_cnt <= '0;
        end else if (!wd_hit) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            timeout_q <= 1'b0;
        end else if (state == S_RUN && wd_hit && !soft_clr && !bus.finish_req && !pending) begin
            timeout_q <= 1'b1;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign wd_hit      = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_HOLD;
            cycle_cnt <= '0;
            pending   <= 1'b0;
            drain_cnt <= '0;
            running_q <= 1'b0;
            finish_q  <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (soft_clr) begin
                state     <= S_HOLD;
                cycle_cnt <= '0;
                pending   <= 1'b0;
                drain_cnt <= '0;
                running_q <= 1'b0;
            end else begin
                case (state)
                    S_HOLD, S_RELEASE: begin
                        if (bus.finish_req) begin
                            pending <= 1'b1;
                        end
                        if (cycle_cnt == LAST_PT) begin
                            state     <= S_RUN;
                            running_q <= 1'b1;
                        end else if (cycle_cnt == FIRST_PT) begin
                            state <= S_RELEASE;
                        end
                    end
                    S_RUN: begin
                        if (bus.finish_req || pending) begin
                            state     <= S_DRAIN;
                            drain_cnt <= '0;
                            pending   <= 1'b0;
                        end else if (wd_hit) begin
                            state     <= S_DONE;
                            running_q <= 1'b0;
                            finish_q  <= 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        if (drain_cnt == DRAIN_LAST) begin
                            state     <= S_DONE;
                            running_q <= 1'b0;
                            finish_q  <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + DRAIN_W'(1);
                        end
                    end
                    S_DONE: begin
                    end
                    default: begin
                        state <= S_HOLD;
                    end
                endcase
            end
        end
    end

    assign bus.dom_rst_n   = dom_q;
    assign bus.running     = running_q;
    assign bus.cycle_count = cycle_cnt;
    assign bus.finish      = finish_q;

endmodule
